// File: rtl/epcs_pkg.sv
// Shared types and constants for the EPCS serial-flash responder.
package epcs_pkg;

  // Transaction phases of the responder.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_STAT,
    ST_DUMMY,
    ST_IDSTR,
    ST_IGNORE
  } epcs_state_e;

  // Supported opcodes.
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RDID = 8'hAB;

  // Bit-counter terminal values (count is zero based).
  localparam logic [4:0] BYTE_LAST = 5'd7;
  localparam logic [4:0] ADDR_LAST = 5'd23;

endpackage

// File: rtl/epcs_sync_edge.sv
// Two-flop synchronizer bank. One input (i_edge) additionally gets a delay
// flop for rise/fall detection; the others are plain level synchronizers.
module epcs_sync_edge #(
  parameter int             W       = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_clk,
  input  logic         reset_reset,
  input  logic         i_edge,
  input  logic [W-1:0] i_async,
  output logic         o_rise,
  output logic         o_fall,
  output logic [W-1:0] o_sync
);

  logic [1:0]   r_edge_ff;
  logic         r_edge_d;
  logic [W-1:0] r_ff1;
  logic [W-1:0] r_ff2;

  // Synchronize all inputs and keep a delayed copy of the edge input.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_edge_ff <= 2'b00;
      r_edge_d  <= 1'b0;
      r_ff1     <= RST_VAL;
      r_ff2     <= RST_VAL;
    end else begin
      r_edge_ff <= {r_edge_ff[0], i_edge};
      r_edge_d  <= r_edge_ff[1];
      r_ff1     <= i_async;
      r_ff2     <= r_ff1;
    end
  end

  assign o_rise = r_edge_ff[1] & ~r_edge_d;
  assign o_fall = ~r_edge_ff[1] & r_edge_d;
  assign o_sync = r_ff2;

endmodule

// File: rtl/epcs_flash_responder.sv
// EPCS (SPI mode 0, MSB first) flash target serving READ, READ STATUS and
// READ ID from a synchronous byte-wide memory port. All logic runs on clk_clk;
// dclk must be at most clk_clk/8 so a memory fetch lands before the next fall.
module epcs_flash_responder
  import epcs_pkg::*;
#(
  parameter int         ADDR_W     = 24,
  parameter logic [7:0] STATUS_VAL = 8'h00,
  parameter logic [7:0] SILICON_ID = 8'h16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              epcs_dclk,
  input  logic              epcs_sce,
  input  logic              epcs_sdo,
  output logic              epcs_data0,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  logic [1:0]  w_sync;
  logic        w_rise;
  logic        w_fall;
  logic        w_sce;
  logic        w_sdo;
  logic [7:0]  w_cmd;
  logic [23:0] w_addr_full;

  epcs_state_e       r_state;
  logic [4:0]        r_bitcnt;
  logic [6:0]        r_shin;
  logic [22:0]       r_addr;
  logic [7:0]        r_shout;
  logic              r_data0;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic              r_rd_d;
  logic              r_cmd_err;

  // sce resets high so busy reads 0 straight out of reset.
  epcs_sync_edge #(
    .W       (2),
    .RST_VAL (2'b01)
  ) u_sync (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .i_edge      (epcs_dclk),
    .i_async     ({epcs_sdo, epcs_sce}),
    .o_rise      (w_rise),
    .o_fall      (w_fall),
    .o_sync      (w_sync)
  );

  assign w_sce       = w_sync[0];
  assign w_sdo       = w_sync[1];
  assign w_cmd       = {r_shin, w_sdo};
  assign w_addr_full = {r_addr, w_sdo};

  // Transaction FSM: input shifting on rises, output shifting on falls,
  // memory fetch on byte boundaries of a READ.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= '0;
      r_shin     <= '0;
      r_addr     <= '0;
      r_shout    <= '0;
      r_data0    <= 1'b0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_rd_d     <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_mem_rd  <= 1'b0;
      r_cmd_err <= 1'b0;
      r_rd_d    <= r_mem_rd;
      if (w_sce) begin
        // Deselect aborts whatever was in flight.
        r_state  <= ST_IDLE;
        r_data0  <= 1'b0;
        r_bitcnt <= '0;
        r_shin   <= '0;
        r_addr   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state  <= ST_CMD;
            r_bitcnt <= '0;
          end
          ST_CMD: begin
            if (w_rise) begin
              r_shin <= w_cmd[6:0];
              if (r_bitcnt == BYTE_LAST) begin
                r_bitcnt <= '0;
                case (w_cmd)
                  OP_READ: r_state <= ST_ADDR;
                  OP_RDSR: begin
                    r_state <= ST_STAT;
                    r_shout <= STATUS_VAL;
                  end
                  OP_RDID: r_state <= ST_DUMMY;
                  default: begin
                    r_cmd_err <= 1'b1;
                    r_state   <= ST_IGNORE;
                  end
                endcase
              end else begin
                r_bitcnt <= r_bitcnt + 5'd1;
              end
            end
          end
          ST_ADDR: begin
            if (w_rise) begin
              r_addr <= w_addr_full[22:0];
              if (r_bitcnt == ADDR_LAST) begin
                r_bitcnt   <= '0;
                r_state    <= ST_DATA;
                r_mem_addr <= w_addr_full[ADDR_W-1:0];
                r_mem_rd   <= 1'b1;
              end else begin
                r_bitcnt <= r_bitcnt + 5'd1;
              end
            end
          end
          ST_DUMMY: begin
            if (w_rise) begin
              if (r_bitcnt == ADDR_LAST) begin
                r_bitcnt <= '0;
                r_state  <= ST_IDSTR;
                r_shout  <= SILICON_ID;
              end else begin
                r_bitcnt <= r_bitcnt + 5'd1;
              end
            end
          end
          ST_DATA, ST_STAT, ST_IDSTR: begin
            if (w_fall) begin
              r_data0 <= r_shout[7];
              r_shout <= {r_shout[6:0], 1'b0};
            end else if (w_rise) begin
              if (r_bitcnt == BYTE_LAST) begin
                // Byte boundary: reload the next output byte before the fall.
                r_bitcnt <= '0;
                case (r_state)
                  ST_DATA: begin
                    r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    r_mem_rd   <= 1'b1;
                  end
                  ST_STAT:  r_shout <= STATUS_VAL;
                  ST_IDSTR: r_shout <= SILICON_ID;
                  default:  ;
                endcase
              end else begin
                r_bitcnt <= r_bitcnt + 5'd1;
              end
            end else if (r_state == ST_DATA && r_rd_d) begin
              r_shout <= mem_rdata;
            end
          end
          ST_IGNORE: r_data0 <= 1'b0;
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign epcs_data0 = r_data0;
  assign mem_addr   = r_mem_addr;
  assign mem_rd     = r_mem_rd;
  assign busy       = ~w_sce;
  assign cmd_err    = r_cmd_err;

endmodule
